conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand width per kernel tap.
REQ-002 Parameter KERNEL_SIZE, default 3: kernel edge; tap count K2 = KERNEL_SIZE*KERNEL_SIZE.
REQ-003 Parameter CHANNELS, default 1: number of accelerator channels.
REQ-004 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 kern_load  in  1  one-cycle request to latch kern_data.
REQ-008 kern_data  in  CHANNELS*K2*DATA_WIDTH  kernel weights.
REQ-009 win_valid  in  1  window available.
REQ-010 win_ready  out  1  window accepted when win_valid & win_ready.
REQ-011 win_data  in  CHANNELS*K2*DATA_WIDTH  pixel window.
REQ-012 mult_a  out  CHANNELS*K2*DATA_WIDTH  multiplier bus, driven from the latched kernel.
REQ-013 mult_b  out  CHANNELS*K2*DATA_WIDTH  multiplicand bus, driven from the latched window.
REQ-014 m_start  out  K2  per-tap multiply start.
REQ-015 c_ready  in  CHANNELS  per-channel accumulate done.
REQ-016 c_sum  in  CHANNELS*32  per-channel accumulated sums.
REQ-017 res_valid  out  1  result valid.
REQ-018 res_ready  in  1  result consumed when res_valid & res_ready.
REQ-019 res_data  out  32  sum of all channel sums.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 timeout_err  out  1  sticky abort flag.

Function
REQ-022 FSM states: IDLE, LOAD, START, WAIT, SUM, OUT.
REQ-023 IDLE: win_ready=1 unless kern_load=1; a handshake latches win_data and moves to LOAD.
REQ-024 kern_load in IDLE latches kern_data in one cycle; kern_load takes priority over win_valid in the same cycle (win_ready=0); kern_load outside IDLE is ignored.
REQ-025 LOAD: mult_a/mult_b present latched operands, held stable through WAIT; next state START.
REQ-026 START: m_start = all ones for exactly one cycle; next state WAIT; m_start = 0 in all other states.
REQ-027 WAIT: c_ready sampled only in this state; each bit set in a done mask and the matching c_sum slice captured on the cycle it is high; later ready pulses for an already-done channel are ignored.
REQ-028 A done mask that is all ones (including bits set this cycle) moves the FSM to SUM on the next edge.
REQ-029 WAIT counter starts at 0 on entry; at count == TIMEOUT with the mask incomplete: set timeout_err, go to IDLE, no result produced.
REQ-030 SUM: res_data = modulo-2^32 sum of captured channel sums, registered in one cycle; next state OUT.
REQ-031 OUT: res_valid=1 and res_data held until res_ready; on handshake go to IDLE; win_ready stays 0.
REQ-032 Latency: a window handshake at edge N gives m_start high in the cycle after edge N+1; with c_ready after edge M, res_valid rises after edge M+2.
REQ-033 timeout_err clears only on reset.

Reset
REQ-034 rst_n low asynchronously forces IDLE, clears kernel and window registers, done mask, counter, res_data, res_valid, m_start, timeout_err, busy; win_ready=1 after release.
REQ-035 Reset mid-operation (any state) discards all in-flight data; no res_valid follows release.

Verification
REQ-036 CHANNELS=1, load kernel of all 1s, window 1..9, model c_ready 3 cycles after m_start with c_sum=45 -> one m_start pulse of 9'h1FF, res_data=45, res_valid held until res_ready.
REQ-037 CHANNELS=2, c_ready[0] then c_ready[1] two cycles apart, sums 0xFFFFFFFF and 2 -> res_data=1 (wrap).
REQ-038 kern_load and win_valid in the same IDLE cycle -> kernel latched, win_ready=0; window accepted on the next cycle.
REQ-039 c_ready never asserted, TIMEOUT=15 -> timeout_err=1 after 15 WAIT cycles, FSM in IDLE, res_valid never 1.
REQ-040 rst_n low during WAIT -> all outputs at reset values immediately; a late c_ready after release produces no result.
REQ-041 res_ready held low 10 cycles in OUT -> res_data stable, win_ready=0, second window not accepted until the handshake.

Source files
------------

// File: rtl/conv_sequencer.sv
// Convolution tap sequencer: latches a kernel and a pixel window, fires all tap
// multipliers at once, gathers per-channel sums and returns their 32-bit total.
module conv_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int CHANNELS    = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             kern_load,
    input  logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] kern_data,
    input  logic                                             win_valid,
    output logic                                             win_ready,
    input  logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
    output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] mult_a,
    output logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] mult_b,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]               m_start,
    input  logic [CHANNELS-1:0]                              c_ready,
    input  logic [CHANNELS*32-1:0]                           c_sum,
    output logic                                             res_valid,
    input  logic                                             res_ready,
    output logic [31:0]                                      res_data,
    output logic                                             busy,
    output logic                                             timeout_err
);

    localparam int K2    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int BUS_W = CHANNELS * K2 * DATA_WIDTH;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_SUM, S_OUT
    } state_t;

    state_t              state_reg, state_next;
    logic [BUS_W-1:0]    kern_reg;
    logic [BUS_W-1:0]    win_reg;
    logic [CHANNELS-1:0] done_reg;
    logic [31:0]         sum_reg [CHANNELS];
    logic [CNT_W-1:0]    cnt_reg;
    logic [31:0]         res_data_reg;
    logic                timeout_reg;

    logic                kern_accept;
    logic                win_hs;
    logic [CHANNELS-1:0] done_now;
    logic                all_done;
    logic                timeout_hit;
    logic [CHANNELS-1:0] cap_en;
    logic [31:0]         sum_slice [CHANNELS];
    logic [31:0]         sum_total;

    assign kern_accept = (state_reg == S_IDLE) && kern_load;
    assign win_hs      = win_valid && win_ready;
    assign done_now    = done_reg | c_ready;
    assign all_done    = &done_now;
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT)) && !all_done;

    // A channel's sum is captured only on its first ready pulse within WAIT.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign cap_en[gi]    = (state_reg == S_WAIT) && c_ready[gi] && !done_reg[gi];
            assign sum_slice[gi] = c_sum[gi*32 +: 32];
        end
    endgenerate

    always_comb begin
        sum_total = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum_total = sum_total + sum_reg[c];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (win_hs) state_next = S_LOAD;
            S_LOAD:  state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (all_done)         state_next = S_SUM;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_SUM:   state_next = S_OUT;
            S_OUT:   if (res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        win_ready = 1'b0;
        m_start   = '0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state_reg)
            S_IDLE: begin
                win_ready = !kern_load;
                busy      = 1'b0;
            end
            S_START: m_start   = '1;
            S_OUT:   res_valid = 1'b1;
            default: ;
        endcase
    end

    assign mult_a      = kern_reg;
    assign mult_b      = win_reg;
    assign res_data    = res_data_reg;
    assign timeout_err = timeout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            kern_reg     <= '0;
            win_reg      <= '0;
            done_reg     <= '0;
            cnt_reg      <= '0;
            res_data_reg <= '0;
            timeout_reg  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) sum_reg[c] <= '0;
        end else begin
            state_reg <= state_next;
            if (kern_accept) kern_reg <= kern_data;
            if (win_hs)      win_reg  <= win_data;
            // Clear bookkeeping on the way into WAIT so the count starts at zero.
            if (state_reg == S_START) begin
                done_reg <= '0;
                cnt_reg  <= '0;
            end
            if (state_reg == S_WAIT) begin
                done_reg <= done_now;
                cnt_reg  <= cnt_reg + CNT_W'(1);
                if (timeout_hit) timeout_reg <= 1'b1;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (cap_en[c]) sum_reg[c] <= sum_slice[c];
            end
            if (state_reg == S_SUM) res_data_reg <= sum_total;
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: single-channel flow, back-pressure, timeout,
// mid-flight reset, and a two-channel wrapping sum on a second instance.
module tb_conv_sequencer;

    localparam int DW   = 32;
    localparam int KS   = 3;
    localparam int K2   = KS * KS;
    localparam int BW_A = 1 * K2 * DW;
    localparam int BW_B = 2 * K2 * DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: one channel, short timeout.
    logic            kern_load_a, win_valid_a, win_ready_a, res_valid_a, res_ready_a;
    logic            busy_a, timeout_err_a;
    logic [BW_A-1:0] kern_data_a, win_data_a, mult_a_a, mult_b_a;
    logic [K2-1:0]   m_start_a;
    logic [0:0]      c_ready_a;
    logic [31:0]     c_sum_a, res_data_a;

    // Instance B: two channels.
    logic            kern_load_b, win_valid_b, win_ready_b, res_valid_b, res_ready_b;
    logic            busy_b, timeout_err_b;
    logic [BW_B-1:0] kern_data_b, win_data_b, mult_a_b, mult_b_b;
    logic [K2-1:0]   m_start_b;
    logic [1:0]      c_ready_b;
    logic [63:0]     c_sum_b;
    logic [31:0]     res_data_b;

    conv_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .CHANNELS(1), .TIMEOUT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .kern_load(kern_load_a), .kern_data(kern_data_a),
        .win_valid(win_valid_a), .win_ready(win_ready_a), .win_data(win_data_a),
        .mult_a(mult_a_a), .mult_b(mult_b_a), .m_start(m_start_a),
        .c_ready(c_ready_a), .c_sum(c_sum_a), .res_valid(res_valid_a),
        .res_ready(res_ready_a), .res_data(res_data_a), .busy(busy_a),
        .timeout_err(timeout_err_a)
    );

    conv_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .CHANNELS(2), .TIMEOUT(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .kern_load(kern_load_b), .kern_data(kern_data_b),
        .win_valid(win_valid_b), .win_ready(win_ready_b), .win_data(win_data_b),
        .mult_a(mult_a_b), .mult_b(mult_b_b), .m_start(m_start_b),
        .c_ready(c_ready_b), .c_sum(c_sum_b), .res_valid(res_valid_b),
        .res_ready(res_ready_b), .res_data(res_data_b), .busy(busy_b),
        .timeout_err(timeout_err_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [BW_A-1:0] kern_ones, win_seq, win_two;
    logic            seen;

    initial begin
        for (int i = 0; i < K2; i++) begin
            kern_ones[i*DW +: DW] = 32'd1;
            win_seq[i*DW +: DW]   = 32'(i + 1);
            win_two[i*DW +: DW]   = 32'(100 + i);
        end
        rst_n = 1'b0;
        kern_load_a = 0; kern_data_a = '0; win_valid_a = 0; win_data_a = '0;
        c_ready_a = '0; c_sum_a = '0; res_ready_a = 0;
        kern_load_b = 0; kern_data_b = '0; win_valid_b = 0; win_data_b = '0;
        c_ready_b = '0; c_sum_b = '0; res_ready_b = 0;
        step(); step();
        check_val("rst_win_ready", win_ready_a, 1);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_res_valid", res_valid_a, 0);
        check_val("rst_m_start", m_start_a, 0);
        check_val("rst_timeout", timeout_err_a, 0);
        rst_n = 1'b1;
        step();

        // Kernel load and window offered together: kernel wins this cycle.
        kern_load_a = 1; kern_data_a = kern_ones; win_valid_a = 1; win_data_a = win_seq;
        #1;
        check_val("kl_prio_ready", win_ready_a, 0);
        step();
        kern_load_a = 0; kern_data_a = '0;
        #1;
        check_val("win_ready_after_kl", win_ready_a, 1);
        check_val("kern_latched", mult_a_a, kern_ones);
        check_val("idle_busy", busy_a, 0);
        step();                                   // edge N: window handshake
        win_valid_a = 0; win_data_a = '0;
        check_val("load_busy", busy_a, 1);
        check_val("load_m_start", m_start_a, 0);
        check_val("win_latched", mult_b_a, win_seq);
        step();                                   // N+1
        check_val("start_pulse", m_start_a, 9'h1FF);
        step();                                   // N+2
        check_val("start_pulse_end", m_start_a, 0);
        step();                                   // N+3
        step();                                   // N+4
        c_ready_a = 1'b1; c_sum_a = 32'd45;
        step();                                   // N+5
        c_ready_a = 1'b0; c_sum_a = '0;
        check_val("sum_no_valid", res_valid_a, 0);
        step();                                   // N+6
        check_val("out_valid", res_valid_a, 1);
        check_val("out_data", res_data_a, 32'd45);
        check_val("kern_held", mult_a_a, kern_ones);

        // Back-pressure: result held, second window refused.
        win_valid_a = 1; win_data_a = win_two;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("hold_valid", res_valid_a, 1);
            check_val("hold_data", res_data_a, 32'd45);
            check_val("hold_win_ready", win_ready_a, 0);
        end
        check_val("hold_win_kept", mult_b_a, win_seq);
        res_ready_a = 1;
        step();                                   // result handshake
        res_ready_a = 0;
        check_val("post_out_valid", res_valid_a, 0);
        check_val("post_out_ready", win_ready_a, 1);
        step();                                   // second window accepted
        win_valid_a = 0; win_data_a = '0;
        check_val("win2_latched", mult_b_a, win_two);
        check_val("win2_busy", busy_a, 1);

        // No c_ready: must abort on timeout without a result.
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (res_valid_a) seen = 1;
        end
        check_val("to_not_early", timeout_err_a, 0);
        for (int i = 0; i < 30; i++) begin
            if (timeout_err_a) break;
            step();
            if (res_valid_a) seen = 1;
        end
        check_val("to_flag", timeout_err_a, 1);
        check_val("to_idle", busy_a, 0);
        check_val("to_no_result", seen, 0);
        step();
        check_val("to_sticky", timeout_err_a, 1);

        // Two channels, second ready two cycles later, first re-pulses with junk.
        win_valid_b = 1;
        step();
        win_valid_b = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_start_b != 0) begin seen = 1; break; end
            step();
        end
        check_val("b_start_seen", seen, 1);
        step();                                   // in WAIT
        c_ready_b = 2'b01; c_sum_b = {32'd0, 32'hFFFF_FFFF};
        step();
        c_ready_b = 2'b00; c_sum_b = '0;
        step();
        c_ready_b = 2'b11; c_sum_b = {32'd2, 32'h0000_1234};
        step();
        c_ready_b = 2'b00; c_sum_b = '0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid_b) begin seen = 1; break; end
            step();
        end
        check_val("b_valid_seen", seen, 1);
        check_val("b_wrap_sum", res_data_b, 32'd1);
        res_ready_b = 1;
        step();
        res_ready_b = 0;
        check_val("b_done_valid", res_valid_b, 0);

        // Reset asserted mid-WAIT: everything clears at once, late ready is ignored.
        win_valid_a = 1; win_data_a = win_seq;
        step();
        win_valid_a = 0;
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", busy_a, 0);
        check_val("arst_timeout", timeout_err_a, 0);
        check_val("arst_mult_a", mult_a_a, 0);
        check_val("arst_mult_b", mult_b_a, 0);
        check_val("arst_m_start", m_start_a, 0);
        check_val("arst_res_valid", res_valid_a, 0);
        check_val("arst_win_ready", win_ready_a, 1);
        step();
        rst_n = 1'b1;
        step();
        c_ready_a = 1'b1; c_sum_a = 32'd77;
        step();
        c_ready_a = 1'b0; c_sum_a = '0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (res_valid_a || busy_a) seen = 1;
        end
        check_val("arst_no_result", seen, 0);
        check_val("arst_res_data", res_data_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
